// File: rtl/dice_pkg.sv
// Shared state encoding and face helpers for the dice roll controller.
// Faces run 1..6; 0 blanks the seven-segment decoder.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    TUMBLE,
    SHOW
  } state_t;

  localparam logic [2:0] FACE_BLANK = 3'd0;
  localparam logic [2:0] FACE_MIN   = 3'd1;
  localparam logic [2:0] FACE_MAX   = 3'd6;

  function automatic logic [2:0] face_inc(
    input logic [2:0] f
  );
    return (f >= FACE_MAX) ? FACE_MIN : f + 3'd1;
  endfunction

  // f in 1..6, k in 0..5; result wrapped into 1..6
  function automatic logic [2:0] face_sub(
    input logic [2:0] f,
    input logic [2:0] k
  );
    logic [2:0] r;
    r = (f > k) ? f - k : f + 3'd6 - k;
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer with
// single-cycle press/release pulses on the debounced level.
module button_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_release
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_press;
  logic        r_release;
  logic [15:0] r_cnt;
  logic        w_diff;
  logic        w_flip;

  assign w_diff = r_sync2 ^ r_level;
  assign w_flip = w_diff &&
    (r_cnt == DEBOUNCE_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_cnt     <= 16'd0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_cnt     <= (w_diff && !w_flip) ?
                   r_cnt + 16'd1 : 16'd0;
      r_press   <= w_flip && !r_level;
      r_release <= w_flip && r_level;
      if (w_flip) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/dice_roll_controller.sv
// Button-driven die roll: spin while held, decelerating tumble
// after release, then hold the captured face until next press.
module dice_roll_controller
  import dice_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [19:0] TICK_CYCLES     = 20'd2500000,
  parameter logic [3:0]  TUMBLE_STEPS    = 4'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_btn,
  output logic [2:0] number,
  output logic       rolling,
  output logic       result_valid,
  output logic       done
);

  localparam logic [23:0] TICK24 = {4'd0, TICK_CYCLES};
  localparam logic [2:0]  TS_MOD =
    3'(TUMBLE_STEPS % 4'd6);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_number;
  logic [2:0]  w_number_nxt;
  logic [2:0]  r_captured;
  logic [2:0]  w_captured_nxt;
  logic [2:0]  r_dice_cnt;
  logic [23:0] r_tick;
  logic [23:0] w_tick_nxt;
  logic [23:0] r_period;
  logic [23:0] w_period_nxt;
  logic [3:0]  r_step;
  logic [3:0]  w_step_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_press;
  logic        w_release;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (roll_btn),
    .o_press  (w_press),
    .o_release(w_release)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_number   <= FACE_BLANK;
      r_captured <= FACE_MIN;
      r_dice_cnt <= FACE_MIN;
      r_tick     <= 24'd0;
      r_period   <= 24'd0;
      r_step     <= 4'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_number   <= w_number_nxt;
      r_captured <= w_captured_nxt;
      r_dice_cnt <= face_inc(r_dice_cnt);
      r_tick     <= w_tick_nxt;
      r_period   <= w_period_nxt;
      r_step     <= w_step_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_number_nxt   = r_number;
    w_captured_nxt = r_captured;
    w_tick_nxt     = r_tick;
    w_period_nxt   = r_period;
    w_step_nxt     = r_step;
    w_done_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_number_nxt = FACE_BLANK;
        if (w_press) begin
          w_state_nxt  = SPIN;
          w_tick_nxt   = 24'd0;
          w_number_nxt = r_dice_cnt;
        end
      end
      SPIN: begin
        w_tick_nxt = r_tick + 24'd1;
        if (w_release) begin
          w_state_nxt    = TUMBLE;
          w_captured_nxt = r_dice_cnt;
          w_number_nxt   = face_sub(r_dice_cnt, TS_MOD);
          w_step_nxt     = 4'd1;
          w_tick_nxt     = 24'd0;
          w_period_nxt   = TICK24;
        end else if (r_tick == TICK24 - 24'd1) begin
          w_number_nxt = r_dice_cnt;
          w_tick_nxt   = 24'd0;
        end
      end
      TUMBLE: begin
        w_tick_nxt = r_tick + 24'd1;
        // period accumulates step*TICK_CYCLES
        if (r_tick == r_period - 24'd1) begin
          w_number_nxt = face_inc(r_number);
          w_tick_nxt   = 24'd0;
          w_period_nxt = r_period + TICK24;
          w_step_nxt   = r_step + 4'd1;
          if (r_step == TUMBLE_STEPS) begin
            w_state_nxt  = SHOW;
            w_number_nxt = r_captured;
            w_done_nxt   = 1'b1;
          end
        end
      end
      SHOW: begin
        if (w_press) begin
          w_state_nxt  = SPIN;
          w_tick_nxt   = 24'd0;
          w_number_nxt = r_dice_cnt;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_number_nxt = FACE_BLANK;
      end
    endcase
  end

  assign number       = r_number;
  assign rolling      = (r_state == SPIN) ||
                        (r_state == TUMBLE);
  assign result_valid = (r_state == SHOW);
  assign done         = r_done;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Scoreboard bench: stimulus queues expected output changes,
// a negedge monitor pops and compares each observed change.
module tb_dice_roll_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       roll_btn = 1'b0;
  logic [2:0] number;
  logic       rolling;
  logic       result_valid;
  logic       done;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  ev_t        q[$];
  ev_t        mon_e;
  logic [5:0] mon_cur;
  logic [5:0] prev = 6'd0;
  logic [5:0] last_exp = 6'd0;
  int         cyc = 0;
  int         R = 0;
  int         checks = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;

  dice_roll_controller #(
    .DEBOUNCE_CYCLES(16'd4),
    .TICK_CYCLES    (20'd3),
    .TUMBLE_STEPS   (4'd5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .roll_btn    (roll_btn),
    .number      (number),
    .rolling     (rolling),
    .result_valid(result_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // expected die counter value just after edge c
  function automatic logic [2:0] dm(input int c);
    return 3'(((c - R) % 6) + 1);
  endfunction

  task automatic push(input int c, input logic [2:0] n,
                      input logic ro, input logic rv,
                      input logic dn);
    ev_t e;
    e.cyc = c;
    e.vec = {n, ro, rv, dn};
    if (e.vec != last_exp) begin
      q.push_back(e);
      last_exp = e.vec;
    end
  endtask

  task automatic chk(input string name, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Release is aligned so the captured face is 4; the tumble
  // then shows 5,6,1,2,3,4 at offsets 0,3,9,18,30,45.
  task automatic do_roll(input int hold, input bit mid,
                         input int cut);
    int c;
    int d;
    int t;
    int offs[7];
    logic [2:0] vals[7];
    offs = '{0, 3, 9, 18, 30, 45, 46};
    vals = '{3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    c = cyc;
    d = c + hold;
    while (((d + 6 - R) % 6) != 3) d++;
    push(c + 7, dm(c + 6), 1'b1, 1'b0, 1'b0);
    for (int s = c + 10; s < d + 7; s += 3)
      push(s, dm(s - 1), 1'b1, 1'b0, 1'b0);
    t = d + 7;
    for (int i = 0; i < 7; i++)
      if (cut == 0 || offs[i] < cut)
        push(t + offs[i], vals[i], i < 5, i >= 5, i == 5);
    if (cut > 0) push(t + cut, 3'd0, 1'b0, 1'b0, 1'b0);
    roll_btn = 1'b1;
    wait_until(d);
    roll_btn = 1'b0;
    if (mid) begin
      wait_until(t + 5);
      roll_btn = 1'b1;
      wait_until(t + 15);
      roll_btn = 1'b0;
    end
    if (cut > 0) begin
      wait_until(t + cut - 1);
      rst = 1'b1;
      wait_until(t + cut);
      rst = 1'b0;
      R = t + cut;
    end else begin
      wait_until(t + 50);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {number, rolling, result_valid, done};
      if (mon_cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got=%b",
                   cyc, mon_cur);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != cyc || mon_e.vec !== mon_cur) begin
            fails++;
            $display("FAIL event cyc=%0d got=%b want cyc=%0d vec=%b",
                     cyc, mon_cur, mon_e.cyc, mon_e.vec);
          end
        end
        prev = mon_cur;
      end
    end
  end

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    R = cyc;
    chk("rst_number", int'(number), 0);
    chk("rst_rolling", int'(rolling), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dice", int'(dut.r_dice_cnt), 1);
    mon_en = 1'b1;

    c = cyc;
    roll_btn = 1'b1;
    wait_until(c + 2);
    roll_btn = 1'b0;
    wait_until(c + 3);
    roll_btn = 1'b1;
    wait_until(c + 5);
    roll_btn = 1'b0;
    wait_until(c + 15);
    chk("bounce_number", int'(number), 0);
    chk("bounce_rolling", int'(rolling), 0);

    do_roll(40, 1'b0, 0);
    chk("roll_number", int'(number), 4);
    chk("roll_valid", int'(result_valid), 1);

    do_roll(15, 1'b0, 0);
    do_roll(12, 1'b1, 0);
    chk("midpress_number", int'(number), 4);

    do_roll(12, 1'b0, 12);
    wait_until(cyc + 60);
    chk("rst_mid_number", int'(number), 0);
    chk("rst_mid_rolling", int'(rolling), 0);
    chk("rst_mid_valid", int'(result_valid), 0);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dice_roll_controller.md
Name: dice_roll_controller

Overview:
Sequences one die roll from a raw push-button to the 3-bit face value driven into the team's seven-segment decoder.
- Synchronises and debounces the button.
- Spins a free-running 1..6 counter while the button is held.
- On release, plays a decelerating "tumble" animation and settles on the captured face.
- Holds the result until the next press.
- Output `number` uses decoder encoding: 0 = blank, 1..6 = face.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable synchronised samples required to change the debounced level (width 16).
- TICK_CYCLES, 20'd2500000: base display step period in cycles; tumble step k (k = 1..TUMBLE_STEPS) lasts k*TICK_CYCLES (width 20).
- TUMBLE_STEPS, 4'd5: number of face advances after release, range 1..15.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- roll_btn, input, 1: raw asynchronous, bouncy push-button, active-high.
- number, output, 3: face to display; 0 = blank, 1..6 valid.
- rolling, output, 1: high in SPIN and TUMBLE.
- result_valid, output, 1: high in SHOW.
- done, output, 1: one-cycle pulse on the cycle SHOW is entered.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state = IDLE; number = 0; rolling, result_valid and done = 0.
  - Synchroniser flops = 0; debounced level = 0; debounce counter = 0.
  - dice_cnt = 1; all tick and step counters = 0.
  - Reset mid-operation in any state gives exactly this state on the next cycle.
- Input conditioning:
  - Two-flop synchroniser on roll_btn.
  - Debounce counter increments while the synchroniser output differs from the debounced level, and clears when they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
  - press = debounced rising edge; release = debounced falling edge; each is a single cycle.
- dice_cnt:
  - Free-running in all states except reset: 1, 2, ..., 6, 1, ... advancing every cycle.
  - Provides the randomness; its value on the release cycle is the result.
- FSM:
  - IDLE: number = 0. On press, go to SPIN; tick counter = 0; number = dice_cnt.
  - SPIN:
    - Every TICK_CYCLES cycles, number loads the current dice_cnt.
    - On release: captured = dice_cnt on that cycle.
    - number = start = captured - (TUMBLE_STEPS mod 6), wrapped into 1..6.
    - step = 1; tick counter = 0; go to TUMBLE.
  - TUMBLE:
    - When the tick counter reaches step*TICK_CYCLES-1: number advances by 1 (6 wraps to 1), step increments, tick counter clears.
    - Implement the step period as an accumulator that adds TICK_CYCLES each step; no multiplier.
    - After the TUMBLE_STEPS-th advance, number equals captured. On that same edge go to SHOW with done = 1.
    - Presses are ignored in this state.
  - SHOW: number holds captured; result_valid = 1. On press, go to SPIN with the same actions as from IDLE.
- Simultaneous events:
  - rst overrides everything.
  - A press and a tick on the same cycle in SHOW: the press wins.
  - A release cannot coincide with a press, because the debounced level changes at most once per cycle.
- Width rules:
  - Tick counter and step accumulator: 24 bits, wide enough for 15*TICK_CYCLES; no overflow for legal parameters.
  - number never takes the values 7 or 0 outside IDLE.

Decomposition:
- Shared package dice_pkg holds:
  - The state enum (IDLE, SPIN, TUMBLE, SHOW).
  - FACE_MIN = 3'd1 and FACE_MAX = 3'd6.
  - FACE_BLANK = 3'd0.
  - A wrap-increment function for 1..6.
- One sub-module, button_debouncer: synchroniser, debounce counter, and press/release pulses, parameterised by DEBOUNCE_CYCLES. It is reusable for future buttons.
- The FSM, dice_cnt and tumble timing live in dice_roll_controller.

Test Plan:
Benches use DEBOUNCE_CYCLES=4, TICK_CYCLES=3, TUMBLE_STEPS=5.
1. Reset: assert rst for 2 cycles then release -> number=0, rolling=0, result_valid=0, done=0, and dice_cnt=1 on the first post-reset cycle.
2. Bounce: roll_btn pulses high for 2 cycles, low for 1, then high for 2, then low -> the debounced level never rises and the state stays IDLE with number=0.
3. Full roll: hold roll_btn for 40 cycles then release. Expected:
   - rolling=1 during the hold.
   - If captured=4, TUMBLE shows 5, 6, 1, 2, 3, 4 with intervals of 3, 6, 9, 12 and 15 cycles (45 cycles total).
   - done pulses exactly once; number stays 4; result_valid=1.
4. Press during TUMBLE: a clean 10-cycle press mid-tumble -> sequence and timing are unchanged and the final result equals captured.
5. Re-roll from SHOW: press -> SPIN entered, result_valid=0, rolling=1, and number is sampled from dice_cnt every 3 cycles, wrapping 6 to 1.
6. Reset mid-TUMBLE: assert rst for 1 cycle during step 3 -> next cycle IDLE, number=0, done never pulses.
